// File: rtl/vip_frame_sequencer.sv
// Framed video source: drains a show-ahead pixel FIFO into a valid/ready stream
// with sop/eol/eop markers, sequencing a configured number of frames.
module vip_frame_sequencer #(
  parameter int unsigned DWIDTH = 24,
  parameter int unsigned DIM_W  = 11,
  parameter int unsigned FRM_W  = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [FRM_W-1:0]  cfg_num_frame,
  input  logic              cfg_start,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic              fifo_rdreq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sop,
  output logic              out_eol,
  output logic              out_eop,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [FRM_W-1:0]  frame_count,
  output logic [15:0]       stall_count
);

  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t             state, state_d;
  logic [DIM_W-1:0]   w_m1, h_m1, x, y;
  logic [FRM_W-1:0]   n_frm;
  logic               can_load, last_x, last_y, last_frame;
  logic               pop, stall, start_ok, start_err, drain_fin;

  assign can_load   = !out_valid || out_ready;
  assign last_x     = (x == w_m1);
  assign last_y     = (y == h_m1);
  assign last_frame = (n_frm != '0) && (FRM_W'(frame_count + FRM_W'(1)) == n_frm);
  assign fifo_rdreq = pop;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Next state and per-cycle strobes; abort overrides every state
  always_comb begin
    state_d   = state;
    pop       = 1'b0;
    stall     = 1'b0;
    start_ok  = 1'b0;
    start_err = 1'b0;
    drain_fin = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_width == '0 || cfg_height == '0) begin
              start_err = 1'b1;
            end else begin
              start_ok = 1'b1;
              state_d  = STREAM;
            end
          end
        end
        STREAM: begin
          if (can_load) begin
            if (!fifo_empty) begin
              pop = 1'b1;
              if (last_x && last_y && last_frame) state_d = DRAIN;
            end else begin
              stall = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (can_load) begin
            drain_fin = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output register, position counters and status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eol     <= 1'b0;
      out_eop     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      frame_count <= '0;
      stall_count <= '0;
      w_m1        <= '0;
      h_m1        <= '0;
      n_frm       <= '0;
      x           <= '0;
      y           <= '0;
    end else begin
      busy    <= (state_d != IDLE);
      done    <= drain_fin;
      cfg_err <= start_err;

      if (abort) begin
        out_valid <= 1'b0;
      end else if (pop) begin
        out_valid <= 1'b1;
        out_data  <= fifo_q;
        out_sop   <= (x == '0) && (y == '0);
        out_eol   <= last_x;
        out_eop   <= last_x && last_y;
      end else if (stall || drain_fin) begin
        out_valid <= 1'b0;
      end

      if (start_ok) begin
        w_m1        <= DIM_W'(cfg_width - DIM_W'(1));
        h_m1        <= DIM_W'(cfg_height - DIM_W'(1));
        n_frm       <= cfg_num_frame;
        x           <= '0;
        y           <= '0;
        frame_count <= '0;
        stall_count <= '0;
      end

      if (pop) begin
        if (last_x) begin
          x <= '0;
          if (last_y) begin
            y           <= '0;
            frame_count <= FRM_W'(frame_count + FRM_W'(1));
          end else begin
            y <= DIM_W'(y + DIM_W'(1));
          end
        end else begin
          x <= DIM_W'(x + DIM_W'(1));
        end
      end

      if (stall && stall_count != {STALL_W{1'b1}})
        stall_count <= STALL_W'(stall_count + STALL_W'(1));
    end
  end

endmodule

// File: tb/tb_vip_frame_sequencer.sv
// Directed bench for vip_frame_sequencer: cycle table for a basic frame plus
// hand sequences for backpressure, underflow gaps, abort, reset and W=1.
module tb_vip_frame_sequencer;

  logic        clock;
  logic        reset_n;
  logic [10:0] cfg_width, cfg_height, cfg_num_frame;
  logic        cfg_start, abort, fifo_empty, fifo_rdreq;
  logic [23:0] fifo_q;
  logic        out_valid, out_ready, out_sop, out_eol, out_eop;
  logic [23:0] out_data;
  logic        busy, done, cfg_err;
  logic [10:0] frame_count;
  logic [15:0] stall_count;

  vip_frame_sequencer dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_num_frame(cfg_num_frame),
    .cfg_start(cfg_start), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eol(out_eol), .out_eop(out_eop),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .frame_count(frame_count), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Show-ahead FIFO model
  logic [23:0] mem [0:63];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  logic        flush = 1'b0;
  logic [5:0]  rd_idx;
  assign rd_idx     = rd_ptr[5:0];
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_q     = mem[rd_idx];
  always @(posedge clock) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rdreq && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        rdy;
    logic        rdreq;
    logic        valid;
    logic [23:0] data;
    logic        sop, eol, eop, dn, bsy;
  } vec_t;
  vec_t tv [11];

  logic [26:0] acc [$];
  logic        hold_pending;
  logic [27:0] prev_vec;
  int          done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] v);
    logic [5:0] wi;
    wi = wr_ptr[5:0];
    mem[wi] = v;
    wr_ptr++;
  endtask

  task automatic flush_fifo();
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
  endtask

  task automatic clr_mon();
    acc.delete();
    hold_pending = 1'b0;
    prev_vec     = '0;
    done_cnt     = 0;
  endtask

  // Leaves the bench at the negedge of the first STREAM cycle
  task automatic start(input int w, input int h, input int n);
    @(negedge clock);
    cfg_width = 11'(w); cfg_height = 11'(h); cfg_num_frame = 11'(n);
    cfg_start = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
  endtask

  // Drive ready for this cycle, check hold/no-pop rules, record accepted words
  task automatic mon(input logic rdy);
    logic [27:0] cur;
    out_ready = rdy;
    #1;
    cur = {out_valid, out_data, out_sop, out_eol, out_eop};
    if (hold_pending) chk("hold_stable", 32'(cur), 32'(prev_vec));
    if (out_valid && !rdy) chk("no_pop_stalled", 32'(fifo_rdreq), 32'(0));
    if (out_valid && rdy) acc.push_back(cur[26:0]);
    if (done) done_cnt++;
    hold_pending = out_valid && !rdy;
    prev_vec     = cur;
  endtask

  task automatic chk_acc(input int i, input logic [23:0] d, input logic s, input logic e, input logic p);
    if (i >= acc.size()) begin
      n_cmp++; n_fail++;
      $display("FAIL word%0d: got missing expected %0h", i, d);
    end else begin
      chk($sformatf("word%0d", i), 32'(acc[i]), 32'({d, s, e, p}));
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_width = '0; cfg_height = '0; cfg_num_frame = '0;
    cfg_start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    clr_mon();

    // Cycle table for W=4 H=2 N=1: rdy rdreq valid data sop eol eop done busy
    tv[0]  = '{1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 24'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 24'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 24'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 24'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 24'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 24'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 24'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 24'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clock);
    #1;
    chk("rst_outputs", 32'({out_valid, out_sop, out_eol, out_eop, busy, done, cfg_err, fifo_rdreq}), 32'(0));
    chk("rst_counts", 32'({frame_count, stall_count}), 32'(0));
    @(negedge clock); reset_n = 1'b1;

    // Basic frame, table driven
    for (int i = 1; i <= 8; i++) push(24'(i));
    start(4, 2, 1);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clock);
      out_ready = tv[i].rdy;
      #1;
      chk($sformatf("t1_rdreq%0d", i), 32'(fifo_rdreq), 32'(tv[i].rdreq));
      chk($sformatf("t1_valid%0d", i), 32'(out_valid), 32'(tv[i].valid));
      chk($sformatf("t1_status%0d", i), 32'({done, busy}), 32'({tv[i].dn, tv[i].bsy}));
      if (tv[i].valid)
        chk($sformatf("t1_word%0d", i), 32'({out_data, out_sop, out_eol, out_eop}),
            32'({tv[i].data, tv[i].sop, tv[i].eol, tv[i].eop}));
    end
    chk("t1_frame_count", 32'(frame_count), 32'(1));
    chk("t1_stall_count", 32'(stall_count), 32'(0));

    // Backpressure: ready toggles 1,0,1,0
    flush_fifo(); clr_mon();
    for (int i = 1; i <= 8; i++) push(24'h100 + 24'(i));
    start(4, 2, 1);
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clock);
      mon(c[0]);
    end
    chk("t2_count", 32'(acc.size()), 32'(8));
    for (int i = 0; i < 8; i++)
      chk_acc(i, 24'h101 + 24'(i), i == 0, i == 3 || i == 7, i == 7);
    chk("t2_done_once", 32'(done_cnt), 32'(1));

    // Underflow gap of 5 cycles between two W=3 H=1 frames
    flush_fifo(); clr_mon();
    for (int i = 1; i <= 3; i++) push(24'h200 + 24'(i));
    start(3, 1, 2);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clock);
      if (c == 9) for (int i = 4; i <= 6; i++) push(24'h200 + 24'(i));
      mon(1'b1);
      if (c >= 5 && c <= 9) chk($sformatf("t3_gap%0d", c), 32'(out_valid), 32'(0));
    end
    chk("t3_stall_count", 32'(stall_count), 32'(5));
    chk("t3_count", 32'(acc.size()), 32'(6));
    for (int i = 0; i < 6; i++)
      chk_acc(i, 24'h201 + 24'(i), i == 0 || i == 3, i == 2 || i == 5, i == 2 || i == 5);
    chk("t3_done_once", 32'(done_cnt), 32'(1));
    chk("t3_frame_count", 32'(frame_count), 32'(2));

    // Rejected start, then abort colliding with start in IDLE
    flush_fifo(); push(24'hABCDEF);
    @(negedge clock);
    cfg_width = 11'd0; cfg_height = 11'd2; cfg_num_frame = 11'd1; cfg_start = 1'b1;
    @(negedge clock); cfg_start = 1'b0; #1;
    chk("t4_cfg_err", 32'({cfg_err, busy, fifo_rdreq}), 32'(3'b100));
    @(negedge clock); #1;
    chk("t4_cfg_err_pulse", 32'({cfg_err, busy, fifo_rdreq}), 32'(0));
    @(negedge clock);
    cfg_width = 11'd2; cfg_height = 11'd1; cfg_start = 1'b1; abort = 1'b1;
    @(negedge clock); cfg_start = 1'b0; abort = 1'b0; #1;
    chk("t4_abort_wins", 32'({cfg_err, busy, fifo_rdreq}), 32'(0));

    // Endless mode aborted after six accepted words
    flush_fifo(); clr_mon();
    for (int i = 1; i <= 10; i++) push(24'h300 + 24'(i));
    start(2, 2, 0);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clock);
      mon(1'b1);
    end
    @(negedge clock); abort = 1'b1;
    mon(1'b0);
    chk("t5_rdreq_abort", 32'(fifo_rdreq), 32'(0));
    @(negedge clock); abort = 1'b0; hold_pending = 1'b0;
    mon(1'b1);
    chk("t5_after_abort", 32'({out_valid, busy, done, fifo_rdreq}), 32'(0));
    chk("t5_frame_count", 32'(frame_count), 32'(1));
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); mon(1'b1);
    end
    chk("t5_no_done", 32'(done_cnt), 32'(0));
    chk("t5_count", 32'(acc.size()), 32'(6));
    for (int i = 0; i < 6; i++)
      chk_acc(i, 24'h301 + 24'(i), i == 0 || i == 4, i[0], i == 3);

    // Asynchronous reset mid-frame, then a clean restart
    flush_fifo(); clr_mon();
    for (int i = 1; i <= 8; i++) push(24'h400 + 24'(i));
    start(4, 2, 1);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clock);
      mon(1'b1);
    end
    @(posedge clock); #2 reset_n = 1'b0; #1;
    chk("t6_rst_flags", 32'({out_valid, out_sop, out_eol, out_eop, busy, done, cfg_err, fifo_rdreq}), 32'(0));
    chk("t6_rst_data", 32'(out_data), 32'(0));
    chk("t6_rst_counts", 32'({frame_count, stall_count}), 32'(0));
    @(negedge clock); reset_n = 1'b1;
    flush_fifo(); clr_mon();
    for (int i = 1; i <= 8; i++) push(24'h500 + 24'(i));
    start(4, 2, 1);
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge clock);
      mon(1'b1);
    end
    chk("t6_count", 32'(acc.size()), 32'(8));
    chk_acc(0, 24'h501, 1'b1, 1'b0, 1'b0);
    chk_acc(7, 24'h508, 1'b0, 1'b1, 1'b1);
    chk("t6_done_once", 32'(done_cnt), 32'(1));

    // W=1: every pixel ends a line
    flush_fifo(); clr_mon();
    push(24'h601); push(24'h602);
    start(1, 2, 1);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clock);
      mon(1'b1);
    end
    chk("t7_count", 32'(acc.size()), 32'(2));
    chk_acc(0, 24'h601, 1'b1, 1'b1, 1'b0);
    chk_acc(1, 24'h602, 1'b0, 1'b1, 1'b1);
    chk("t7_done_once", 32'(done_cnt), 32'(1));
    chk("t7_frame_count", 32'(frame_count), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vip_frame_sequencer.md
Name: vip_frame_sequencer

Overview:
- Drains pixel words from the input pixel FIFO (written by the image generator or the upstream capture path) and emits them as a framed video stream: valid/ready handshake with start-of-packet, end-of-line and end-of-packet markers.
- Software or bench config sets frame width, height and frame count; the block sequences whole frames and reports completion.
- Sits between the input FIFO and the first vip_core processing stage.

Parameters:
DWIDTH, 24, pixel word width (packed {R,G,B}, 8 bits each)
DIM_W, 11, width of the width, height, x and y counters
FRM_W, 11, width of the frame counters

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cfg_width  in  DIM_W  pixels per line, sampled on cfg_start
cfg_height  in  DIM_W  lines per frame, sampled on cfg_start
cfg_num_frame  in  FRM_W  frames to send; 0 = run until abort
cfg_start  in  1  one-cycle start pulse, honoured only in IDLE
abort  in  1  synchronous abort, any state
fifo_empty  in  1  input FIFO empty (show-ahead FIFO)
fifo_q  in  DWIDTH  FIFO head word, valid while !fifo_empty
fifo_rdreq  out  1  pop FIFO head this cycle
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts when high with out_valid
out_data  out  DWIDTH  pixel word
out_sop  out  1  first pixel of frame (x=0,y=0)
out_eol  out  1  last pixel of a line (x=W-1)
out_eop  out  1  last pixel of frame (x=W-1,y=H-1)
busy  out  1  high in STREAM and DRAIN
done  out  1  one-cycle pulse when the requested frames are fully accepted
cfg_err  out  1  one-cycle pulse when a start is rejected
frame_count  out  FRM_W  completed frames since last start
stall_count  out  16  saturating count of FIFO-underflow stall cycles

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE. All outputs 0, including the counters and the latched config.
- The output stage is a single register (out_valid, out_data, out_sop, out_eol, out_eop).
  - "can_load" = !out_valid || out_ready.
  - While out_valid && !out_ready, all out_* fields hold stable.
- IDLE:
  - busy=0; fifo_rdreq=0.
  - cfg_start with cfg_width=0 or cfg_height=0: cfg_err=1 for one cycle, stay in IDLE.
  - Otherwise: latch W, H, N; clear x, y, frame_count and stall_count; go to STREAM on the next cycle.
- STREAM:
  - fifo_rdreq = !fifo_empty && can_load; this is combinational, and there is no pop without a load.
  - On a pop:
    - out_data <= fifo_q; out_valid <= 1.
    - out_sop <= (x==0 && y==0); out_eol <= (x==W-1); out_eop <= (x==W-1 && y==H-1).
    - Then advance: x++. At x==W-1, x <= 0 and y++. At y==H-1 also, y <= 0 and frame_count++.
  - If can_load && !pop (FIFO empty): out_valid <= 0; stall_count++ saturating at 0xFFFF.
  - After popping the eop pixel, with N!=0 and frame_count+1==N: go to DRAIN.
  - With N==0, wrap to the next frame indefinitely; frame_count wraps modulo 2^FRM_W.
- DRAIN:
  - fifo_rdreq=0.
  - When out_valid && out_ready, or !out_valid: out_valid <= 0, done <= 1 for one cycle, go to IDLE.
- abort (any state, priority over everything except reset):
  - Next cycle: state=IDLE, out_valid=0, fifo_rdreq=0 in the abort cycle.
  - No done pulse; frame_count holds its value.
- cfg_start in STREAM or DRAIN is ignored (no cfg_err). Config inputs are not re-sampled mid-run.
- Simultaneous abort and cfg_start in IDLE: abort wins, no start.
- Latency: a FIFO word popped in cycle t appears on out_data in cycle t+1. Throughput is 1 word/cycle with a non-empty FIFO and ready held high.
- Arithmetic: x/y comparisons use latched W-1/H-1 at DIM_W bits. W=1 is legal, and every pixel then has eol=1.

Test Plan:
- W=4, H=2, N=1, FIFO preloaded with 8 words 0x000001..0x000008, ready=1 -> 8 consecutive valid cycles; sop on word 1; eol on words 4 and 8; eop on word 8; done 1 cycle after the last accept; frame_count=1.
- Same config, out_ready toggling 1,0,1,0 -> each word held stable while ready=0; no pop while stalled; data order intact.
- W=3, H=1, N=2, FIFO empty for 5 cycles between frames -> out_valid=0 during the gap; stall_count=5; sop on words 1 and 4; done after word 6.
- cfg_start with cfg_width=0 -> cfg_err pulse; busy stays 0; no fifo_rdreq.
- N=0, W=2, H=2, 10 words supplied, abort after word 6 accepted -> stream stops; out_valid=0 the next cycle; no done; frame_count=1.
- reset_n asserted mid-frame (asynchronous, off clock edge) -> all outputs 0 immediately; a fresh cfg_start then restarts with sop on the first word.
